// File: rtl/nest_counter_rt_pkg.sv
// ============================================================================
// nest_counter_rt_pkg : shared state encoding for the nested loop counter
// Revision 1.0
// ============================================================================
`default_nettype none

package nest_counter_rt_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/nest_counter_rt_level.sv
// ============================================================================
// nest_counter_level : one runtime-bounded level of the nested loop counter
// Revision 1.0
// ============================================================================
`default_nettype none

module nest_counter_level #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step_in,
  input  logic [CW-1:0] bound,
  output logic [CW-1:0] cnt,
  output logic          at_max,
  output logic          step_out
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max   = (cnt_q == bound - CW'(1));
  assign step_out = step_in && at_max;
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step_in) begin
      cnt_d = at_max ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nest_counter_rt.sv
// ============================================================================
// nest_counter_rt : N-level nested loop counter with runtime bounds, emitting
//                   one index tuple per valid/ready handshake. Revision 1.0
// ============================================================================
`default_nettype none

module nest_counter_rt
  import nest_counter_rt_pkg::*;
#(
  parameter int CW   = 16,
  parameter int NEST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NEST*CW-1:0] bound,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEST*CW-1:0] cnt,
  output logic [NEST-1:0]    last_vec,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [NEST*CW-1:0] bound_q, bound_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic [NEST:0]      step;
  logic [NEST-1:0]    at_max;
  logic               clr;
  logic               any_zero;
  logic               final_xfer;

  // abort outranks a same-cycle handshake, so it also blocks the carry chain
  assign step[0]    = out_valid_q && out_ready && !abort;
  assign final_xfer = step[NEST];
  assign clr        = (state_q == ST_RUN) && abort;

  generate
    for (genvar k = 0; k < NEST; k++) begin : g_level
      nest_counter_level #(
        .CW (CW)
      ) u_level (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .step_in  (step[k]),
        .bound    (bound_q[k*CW +: CW]),
        .cnt      (cnt[k*CW +: CW]),
        .at_max   (at_max[k]),
        .step_out (step[k+1])
      );
    end
  endgenerate

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < NEST; k++) begin
      if (bound[k*CW +: CW] == '0) begin
        any_zero = 1'b1;
      end
    end
  end

  always_comb begin
    last_vec[0] = out_valid_q && at_max[0];
    for (int k = 1; k < NEST; k++) begin
      last_vec[k] = last_vec[k-1] && at_max[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    bound_d     = bound_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          bound_d = bound;
          if (any_zero) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_RUN;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else if (final_xfer) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bound_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bound_q     <= bound_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

`default_nettype wire
